// File: rtl/playseq_detector_jogada.sv
// PlaySeq button conditioner: 2-FF sync, debounce, one-hot check, single-cycle play pulse (optional macro PLAYSEQ_ERRO_MULTIPLO_EN adds erro_multiplo).
// Latency: tem_jogada about DEBOUNCE_CICLOS+4 cycles after a clean press; jogada/jogada_cod valid with the pulse.
// Backpressure: none; after a play the block ignores presses until a debounced full release.
module playseq_detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int W_DEB           = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic                tem_jogada,
  output logic [N_BOTOES-1:0] jogada,
  output logic [1:0]          jogada_cod,
  output logic                ocupado,
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
  output logic                erro_multiplo,
`endif
  output logic [2:0]          db_estado
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRA_PRESS  = 3'd1,
    VALIDA        = 3'd2,
    ACEITA        = 3'd3,
    ESPERA_SOLTAR = 3'd4,
    FILTRA_SOLTA  = 3'd5
  } estado_t;

  localparam logic [W_DEB-1:0] L_ALVO = W_DEB'(DEBOUNCE_CICLOS - 1);
  localparam logic [W_DEB-1:0] L_MAX  = W_DEB'(DEBOUNCE_CICLOS);

  logic [N_BOTOES-1:0] r_sync1, r_sync2, r_prev, r_cand, r_jogada;
  logic [W_DEB-1:0]    r_cnt;
  logic [1:0]          r_cod, w_cod_cand;
  estado_t             r_estado, w_prox;
  logic                w_estavel, w_vazio, w_fim, w_erro;

  assign w_estavel = (r_sync2 == r_prev);
  assign w_vazio   = (r_sync2 == '0);
  assign w_fim     = w_estavel && (r_cnt == L_ALVO);

  always_comb begin
    w_cod_cand = 2'd0;
    for (int i = 0; i < N_BOTOES; i++)
      if (r_cand[i]) w_cod_cand = 2'(i);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= botoes;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Counter restarts on every state change so each filter phase measures a full window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              r_cnt <= '0;
    else if (w_prox != r_estado || !w_estavel) r_cnt <= '0;
    else if (r_cnt != L_MAX)                   r_cnt <= r_cnt + W_DEB'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
      r_cand   <= '0;
      r_jogada <= '0;
      r_cod    <= 2'd0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == FILTRA_PRESS && w_prox == VALIDA) r_cand <= r_sync2;
      if (w_prox == ACEITA) begin
        r_jogada <= r_cand;
        r_cod    <= w_cod_cand;
      end
    end
  end

  always_comb begin
    w_prox     = r_estado;
    tem_jogada = 1'b0;
    ocupado    = 1'b1;
    w_erro     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        ocupado = 1'b0;
        if (!w_vazio) w_prox = habilita ? FILTRA_PRESS : ESPERA_SOLTAR;
      end
      FILTRA_PRESS: begin
        if (w_vazio)        w_prox = OCIOSO;
        else if (!habilita) w_prox = ESPERA_SOLTAR;
        else if (w_fim)     w_prox = VALIDA;
      end
      VALIDA: begin
        w_prox = (habilita && $onehot(r_cand)) ? ACEITA : ESPERA_SOLTAR;
        w_erro = habilita && !$onehot0(r_cand);
      end
      ACEITA: begin
        tem_jogada = 1'b1;
        w_prox     = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (w_vazio) w_prox = FILTRA_SOLTA;
      end
      FILTRA_SOLTA: begin
        if (!w_vazio)   w_prox = ESPERA_SOLTAR;
        else if (w_fim) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  assign jogada     = r_jogada;
  assign jogada_cod = r_cod;
  assign db_estado  = r_estado;

`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
  assign erro_multiplo = w_erro;
`else
  logic w_erro_nc;
  assign w_erro_nc = w_erro;
`endif

endmodule

// File: tb/tb_playseq_detector_jogada.sv
// Bench for playseq_detector_jogada: press/release episodes, directed then random, against an episode-level model.
// Model predicts per episode: pulse count, pulse latency window, captured button, held outputs, idle state.
// No backpressure on this block; stimulus is driven freely one cycle at a time.
module tb_playseq_detector_jogada;
  localparam int DEB = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] botoes;
  logic       habilita;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic [1:0] jogada_cod;
  logic       ocupado;
  logic [2:0] db_estado;
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
  logic       erro_multiplo;
  int         erro_tot = 0;
`endif

  playseq_detector_jogada #(.N_BOTOES(4), .DEBOUNCE_CICLOS(DEB), .W_DEB(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .botoes     (botoes),
    .habilita   (habilita),
    .tem_jogada (tem_jogada),
    .jogada     (jogada),
    .jogada_cod (jogada_cod),
    .ocupado    (ocupado),
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
    .erro_multiplo (erro_multiplo),
`endif
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  int         n_vec = 0, n_err = 0;
  int         cyc = 0, pulse_tot = 0, pulse_cyc = 0;
  logic [3:0] pulse_jog = 4'd0;
  logic [1:0] pulse_cod = 2'd0;
  logic [3:0] m_jog;
  logic [3:0] rp;
  int         rmode, rnb, rhold, rdrop, rrst;
  bit         rh, rshort;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (tem_jogada) begin
      pulse_tot = pulse_tot + 1;
      pulse_cyc = cyc;
      pulse_jog = jogada;
      pulse_cod = jogada_cod;
    end
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
    if (erro_multiplo) erro_tot = erro_tot + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int nbits(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int enc(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One press/release episode starting from idle; outcome predicted from the button rules alone.
  task automatic episode(input logic [3:0] p, input bit h, input int nb, input int hold,
                         input bit short_rel, input int drop_at, input int rst_at);
    int base, s, d, t;
    bit acc, err_exp;
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
    int e0;
`endif
    logic [3:0] b;
    acc     = h && nbits(p) == 1 && drop_at == 0;
    err_exp = h && nbits(p) >= 2 && drop_at == 0;
    chk("idle_ocupado", 32'(ocupado), 32'd0);
    chk("idle_estado", 32'(db_estado), 32'd0);
    habilita = h;
    base = pulse_tot;
    for (int i = 0; i < nb; i++) begin
      do b = 4'($urandom); while (b == 4'd0);
      botoes = b;
      tick(1 + $urandom_range(2));
      botoes = 4'd0;
      tick(1 + $urandom_range(2));
    end
    chk("bounce_no_pulse", 32'(pulse_tot - base), 32'd0);
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
    e0 = erro_tot;
`endif
    botoes = p;
    s = cyc;
    t = 0;
    while (t < hold) begin
      tick(1);
      t++;
      if (t == drop_at) habilita = 1'b0;
      if (t == rst_at) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_tem", 32'(tem_jogada), 32'd0);
        chk("rst_jogada", 32'(jogada), 32'd0);
        chk("rst_cod", 32'(jogada_cod), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_estado", 32'(db_estado), 32'd0);
        m_jog = 4'd0;
        tick(1);
        reset_n = 1'b1;
        s = cyc;
        base = pulse_tot;
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
        e0 = erro_tot;
`endif
        t++;
      end
    end
    chk("hold_estado", 32'(db_estado), 32'd4);
    chk("hold_ocupado", 32'(ocupado), 32'd1);
    chk("n_pulse", 32'(pulse_tot - base), 32'(acc));
    if (acc) begin
      d = pulse_cyc - s;
      chk("pulse_latency_in_window", 32'(d >= 11 && d <= 13), 32'd1);
      chk("pulse_jogada", 32'(pulse_jog), 32'(p));
      chk("pulse_cod", 32'(pulse_cod), 32'(enc(p)));
      m_jog = p;
    end
    chk("held_jogada", 32'(jogada), 32'(m_jog));
    botoes = 4'd0;
    if (short_rel) begin
      tick(1 + $urandom_range(4));
      botoes = p;
      tick(15);
      chk("repress_estado", 32'(db_estado), 32'd4);
      botoes = 4'd0;
    end
    tick(25);
    chk("total_pulses", 32'(pulse_tot - base), 32'(acc));
    chk("end_jogada", 32'(jogada), 32'(m_jog));
    chk("end_cod", 32'(jogada_cod), 32'(enc(m_jog)));
    chk("end_ocupado", 32'(ocupado), 32'd0);
    chk("end_estado", 32'(db_estado), 32'd0);
`ifdef PLAYSEQ_ERRO_MULTIPLO_EN
    chk("erro_pulses", 32'(erro_tot - e0), 32'(err_exp));
`else
    if (err_exp) chk("multi_no_pulse", 32'(pulse_tot - base), 32'd0);
`endif
    habilita = 1'b1;
    tick(2);
  endtask

  initial begin
    reset_n  = 1'b1;
    botoes   = 4'd0;
    habilita = 1'b1;
    m_jog    = 4'd0;
    #1 reset_n = 1'b0;
    #2;
    chk("por_tem", 32'(tem_jogada), 32'd0);
    chk("por_jogada", 32'(jogada), 32'd0);
    chk("por_cod", 32'(jogada_cod), 32'd0);
    chk("por_ocupado", 32'(ocupado), 32'd0);
    chk("por_estado", 32'(db_estado), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);

    episode(4'b0100, 1'b1, 0, 20,  1'b0, 0, 0);
    episode(4'b0001, 1'b1, 3, 30,  1'b0, 0, 0);
    episode(4'b0011, 1'b1, 0, 20,  1'b0, 0, 0);
    episode(4'b1000, 1'b0, 0, 20,  1'b0, 0, 0);
    episode(4'b1000, 1'b1, 0, 20,  1'b0, 0, 0);
    episode(4'b0010, 1'b1, 0, 100, 1'b1, 0, 0);
    episode(4'b0100, 1'b1, 0, 40,  1'b0, 6, 0);
    episode(4'b0001, 1'b1, 0, 40,  1'b0, 0, 5);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(9) < 7) rp = 4'b0001 << $urandom_range(3);
      else do rp = 4'($urandom); while (rp == 4'd0);
      rmode  = $urandom_range(9);
      rh     = (rmode < 2) ? 1'b1 : ($urandom_range(4) != 0);
      rdrop  = (rmode == 0) ? 3 + $urandom_range(7) : 0;
      rrst   = (rmode == 1) ? 2 + $urandom_range(7) : 0;
      rnb    = $urandom_range(2);
      rhold  = 30 + $urandom_range(30);
      rshort = 1'($urandom_range(1));
      episode(rp, rh, rnb, rhold, rshort, rdrop, rrst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/playseq_detector_jogada.md
Name: playseq_detector_jogada

Overview:
- Input conditioner for the PlaySeq button panel. Feeds the PlaySeq control unit and datapath.
- Synchronises and debounces the raw player buttons, and validates that exactly one button is pressed.
- Emits a single-cycle tem_jogada pulse with the registered one-hot and encoded button value.
- Re-arms only after all buttons are released and that release is stable.

Parameters:
- N_BOTOES, 4: number of player buttons. Must be 4 for the 2-bit code.
- DEBOUNCE_CICLOS, 50000: stable cycles required before accepting a press or a release. Minimum 2.
- W_DEB, 16: debounce counter width. Must satisfy 2^W_DEB > DEBOUNCE_CICLOS.

Ports:
- clock, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous reset, active-low.
- botoes, input, N_BOTOES: raw button levels, active-high, asynchronous to clock.
- habilita, input, 1: when 0, presses are not accepted.
- tem_jogada, output, 1: one-cycle pulse marking an accepted play.
- jogada, output, N_BOTOES: registered one-hot of the accepted button. Held until the next accepted play.
- jogada_cod, output, 2: binary code of jogada (bit0→0 … bit3→3). Held with jogada.
- ocupado, output, 1: high in every state except OCIOSO.
- db_estado, output, 3: encoded current state.

Behaviour:
- Reset (reset_n=0, async): state OCIOSO, sync flops 0, debounce counter 0, tem_jogada=0, jogada=0, jogada_cod=0, ocupado=0.
- Synchroniser:
  - 2-FF per bit; the FSM sees botoes_s = the second stage only.
  - Input-to-visible latency is 2 cycles.
- Debounce counter:
  - Cleared on every state entry.
  - Cleared whenever botoes_s differs from the previous-cycle copy.
  - Increments otherwise, saturating at DEBOUNCE_CICLOS.
- States:
  - OCIOSO (0):
    - botoes_s≠0 and habilita=1 → FILTRA_PRESS.
    - botoes_s≠0 and habilita=0 → ESPERA_SOLTAR. The press is discarded.
  - FILTRA_PRESS (1):
    - botoes_s==0 → OCIOSO (glitch).
    - Counter reaches DEBOUNCE_CICLOS-1 with a stable value → VALIDA.
    - botoes_s sampled on that cycle is captured into reg_cand.
  - VALIDA (2):
    - reg_cand exactly one-hot → ACEITA.
    - Otherwise → ESPERA_SOLTAR, with no pulse and jogada unchanged.
  - ACEITA (3):
    - tem_jogada=1 for this one cycle.
    - jogada and jogada_cod load from reg_cand on entry, so they are valid in the same cycle as the pulse.
    - Next state is ESPERA_SOLTAR unconditionally.
  - ESPERA_SOLTAR (4): botoes_s==0 → FILTRA_SOLTA.
  - FILTRA_SOLTA (5):
    - Any botoes_s≠0 → ESPERA_SOLTAR.
    - Counter reaches DEBOUNCE_CICLOS-1 with all zero → OCIOSO.
- Accept latency: the tem_jogada pulse comes 2 + DEBOUNCE_CICLOS + 2 cycles after a clean single press (±1 with counter phase; the bench checks a window of 3).
- Holding a button produces exactly one pulse; a new pulse needs a full debounced release first.
- habilita falling while in FILTRA_PRESS or VALIDA: the FSM goes to ESPERA_SOLTAR with no pulse.
- habilita has no effect once in ACEITA.
- A second button added during FILTRA_PRESS resets the counter. Acceptance then depends on the final stable value.
- Reset asserted in any state: immediate return to reset values. No pulse is emitted on deassertion.

Optional Feature:
- Macro PLAYSEQ_ERRO_MULTIPLO_EN.
- Defined:
  - Adds output erro_multiplo (1 bit), reset 0.
  - Pulses for one cycle in VALIDA when reg_cand has ≥2 bits set.
  - jogada is unchanged and there is no tem_jogada.
- Undefined:
  - The port is absent.
  - Multi-button presses are silently discarded.

Test Plan (DEBOUNCE_CICLOS=8 for sim):
- Reset, then botoes=0100 held 20 cycles, then 0000 held 20 cycles → exactly one tem_jogada pulse at cycle 12±1; jogada=0100, jogada_cod=2 held afterwards; ocupado back to 0 after release filtering.
- botoes=0001 with 3-cycle bounces (0001/0000/0001) before stabilising → one pulse only, jogada_cod=0; no pulse during the bounces.
- botoes=0011 stable 20 cycles → no tem_jogada; jogada keeps its previous value. With PLAYSEQ_ERRO_MULTIPLO_EN: erro_multiplo pulses once.
- habilita=0, press 1000 then release, then habilita=1 → no pulse; a later clean 1000 press → pulse with jogada_cod=3.
- Hold 0010 for 100 cycles → exactly one pulse. A release shorter than 8 cycles followed by a repress → no second pulse.
- reset_n pulled low mid-FILTRA_PRESS → all outputs 0 in the same cycle (async). After deassert with button still held → pulse after a full debounce.
